hdmi_reset_seq: RTL and testbench
=================================

Name: hdmi_reset_seq

Overview:
Reset/enable sequencer for the HDMI output path, on the 25 MHz board-clock domain.
- Waits for the PLL to report stable lock.
- Releases the TMDS-domain reset first, then the pixel-domain reset, then asserts video_en to the pixel/encoder stage.
- On loss of lock or a soft restart, drops everything back into reset and re-sequences.
- Consumers re-synchronise rst_tmds, rst_px and video_en into their own clock domains.

Parameters:
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised lock-high cycles required before release (>=2).
- STAGE_GAP, 16, cycles spent in each release stage and in FAULT (>=2).
- LOSS_CNT_W, 8, width of the lock-loss counter (optional feature only).

Ports:
- clk_25mhz  in  1  board clock.
- reset  in  1  synchronous, active-high.
- pll_locked  in  1  PLL lock, asynchronous to clk_25mhz.
- soft_restart  in  1  single-cycle request to re-sequence.
- rst_tmds  out  1  active-high reset for the TMDS/serialiser domain.
- rst_px  out  1  active-high reset for the pixel/encoder domain.
- video_en  out  1  high when the output path may emit video.
- seq_state  out  3  current state encoding (debug).

Behaviour:
- Interface decisions: reset is synchronous, active-high; clock is clk_25mhz. All logic is on clk_25mhz.
- pll_locked passes through a 2-flop synchroniser (flops reset to 0); the result is lock_s.
- One counter, width $clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP)). It clears on every state change.
- States (encoding): WAIT_LOCK=0, REL_TMDS=1, REL_PX=2, RUN=3, FAULT=4.
- All outputs are registered Moore decodes, updated on the same edge as the state:
  - WAIT_LOCK: rst_tmds=1, rst_px=1, video_en=0.
  - REL_TMDS: rst_tmds=0, rst_px=1, video_en=0.
  - REL_PX: rst_tmds=0, rst_px=0, video_en=0.
  - RUN: rst_tmds=0, rst_px=0, video_en=1.
  - FAULT: rst_tmds=1, rst_px=1, video_en=0.
- Reset: state=WAIT_LOCK, counter=0, rst_tmds=1, rst_px=1, video_en=0, seq_state=0. Asserting reset mid-sequence returns here on the next edge.
- WAIT_LOCK:
  - lock_s=1: counter increments.
  - lock_s=0: counter clears.
  - lock_s=1 with counter==LOCK_STABLE_CYCLES-1: go to REL_TMDS.
  - soft_restart is ignored in this state.
- REL_TMDS and REL_PX: each occupies exactly STAGE_GAP cycles, then advances (REL_TMDS->REL_PX->RUN).
- RUN: holds indefinitely.
- Exit to FAULT from REL_TMDS/REL_PX/RUN when lock_s=0 or soft_restart=1.
  - Lock loss has priority over the stage-advance transition.
  - If both exit conditions occur together, it is classed as a lock loss.
- FAULT: occupies exactly STAGE_GAP cycles regardless of inputs, then goes to WAIT_LOCK with counter=0.
- Glitches: a lock_s glitch in WAIT_LOCK restarts the stability count; there is no hysteresis beyond this.
- Latency:
  - Edge 0 is the first edge sampling pll_locked=1. lock_s is high after edge 1.
  - rst_tmds falls after edge LOCK_STABLE_CYCLES+1.
  - rst_px falls STAGE_GAP edges later; video_en rises another STAGE_GAP edges later.
  - pll_locked falling in RUN gives video_en=0 and both resets=1 two edges later.

Optional Feature:
- Macro: HDMI_RESET_SEQ_LOSS_COUNT_EN.
- Defined:
  - Adds output port loss_count [LOSS_CNT_W-1:0]: a saturating count of FAULT entries caused by lock loss (soft restarts are not counted).
  - Cleared only by reset; increments on the edge that enters FAULT and holds at all-ones.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package hdmi_pkg holds:
  - the seq_state enum/localparams (WAIT_LOCK..FAULT, 3 bits);
  - the default-parameter constants;
  - a clog2-max helper function.
- One sub-module: hdmi_sync_2ff (single-bit 2-flop synchroniser with synchronous reset), instantiated for pll_locked.

Test Plan (LOCK_STABLE_CYCLES=8, STAGE_GAP=4 unless stated):
- Clean power-up: reset 4 cycles, then pll_locked=1 -> rst_tmds falls after edge 9, rst_px after edge 13, video_en rises after edge 17; seq_state passes 0,1,2,3.
- Unstable lock: pll_locked high 5 cycles, low 1 cycle, then high -> the count restarts; rst_tmds falls 9 edges after the final rise, never earlier.
- Lock loss in RUN: drop pll_locked -> video_en=0, rst_tmds=rst_px=1 two edges later; seq_state=4 for 4 cycles, then 0; with lock held, re-sequences to RUN.
- Soft restart and reset mid-sequence:
  - soft_restart pulse in REL_PX -> FAULT next edge.
  - soft_restart in WAIT_LOCK -> no effect.
  - reset asserted in REL_TMDS -> all outputs at reset values next edge.
- HDMI_RESET_SEQ_LOSS_COUNT_EN with LOSS_CNT_W=2: 5 lock losses from RUN -> loss_count reads 1,2,3,3,3; soft restarts leave it unchanged.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types, defaults and helpers for the HDMI reset/enable sequencer.
// Optional lock-loss counter is enabled with `define HDMI_RESET_SEQ_LOSS_COUNT_EN.
package hdmi_pkg;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StRelTmds  = 3'd1,
    StRelPx    = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic rst_tmds;
    logic rst_px;
    logic video_en;
  } seq_out_t;

  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefStageGap         = 16;
  localparam int unsigned DefLossCntW         = 8;

  function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

  // Moore decode shared by every state; unknown encodings behave like WAIT_LOCK.
  function automatic seq_out_t decode_state(input seq_state_e st);
    seq_out_t o;
    o = '{rst_tmds: 1'b1, rst_px: 1'b1, video_en: 1'b0};
    case (st)
      StRelTmds: o = '{rst_tmds: 1'b0, rst_px: 1'b1, video_en: 1'b0};
      StRelPx:   o = '{rst_tmds: 1'b0, rst_px: 1'b0, video_en: 1'b0};
      StRun:     o = '{rst_tmds: 1'b0, rst_px: 1'b0, video_en: 1'b1};
      default:   o = '{rst_tmds: 1'b1, rst_px: 1'b1, video_en: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/hdmi_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset.
module hdmi_sync_2ff (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdmi_reset_seq.sv
// HDMI output-path reset/enable sequencer on the 25 MHz board clock.
// Define HDMI_RESET_SEQ_LOSS_COUNT_EN to add the saturating loss_count output.
module hdmi_reset_seq
  import hdmi_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
  parameter int unsigned STAGE_GAP          = DefStageGap,
  parameter int unsigned LOSS_CNT_W         = DefLossCntW
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  soft_restart,
  output logic                  rst_tmds,
  output logic                  rst_px,
  output logic                  video_en,
`ifdef HDMI_RESET_SEQ_LOSS_COUNT_EN
  output logic [LOSS_CNT_W-1:0] loss_count,
`endif
  output logic [2:0]            seq_state
);

  localparam int unsigned CntW = clog2_max(LOCK_STABLE_CYCLES, STAGE_GAP);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);

  logic lock_s;

  hdmi_sync_2ff u_lock_sync (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .d_i       (pll_locked),
    .q_o       (lock_s)
  );

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  seq_out_t        out_q, out_d;
  logic            lock_loss;
  logic            exit_req;

  always_comb begin
    lock_loss = ~lock_s;
    exit_req  = lock_loss | soft_restart;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;

    case (state_q)
      StWaitLock: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StRelTmds;
        end
      end
      StRelTmds: begin
        if (exit_req) begin
          state_d = StFault;
        end else if (cnt_q == GapLast) begin
          state_d = StRelPx;
        end
      end
      StRelPx: begin
        if (exit_req) begin
          state_d = StFault;
        end else if (cnt_q == GapLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Counter is not needed here; parking it avoids a free-running wrap.
        cnt_d = '0;
        if (exit_req) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (cnt_q == GapLast) begin
          state_d = StWaitLock;
        end
      end
      default: begin
        state_d = StWaitLock;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    out_d = decode_state(state_d);
  end

`ifdef HDMI_RESET_SEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  fault_entry;

  always_comb begin
    fault_entry = (state_d == StFault) && (state_q != StFault);
    loss_d      = loss_q;
    // A simultaneous lock loss and soft restart counts as a lock loss.
    if (fault_entry && lock_loss && (loss_q != '1)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^LOSS_CNT_W;
`endif

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      out_q   <= '{rst_tmds: 1'b1, rst_px: 1'b1, video_en: 1'b0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign rst_tmds  = out_q.rst_tmds;
  assign rst_px    = out_q.rst_px;
  assign video_en  = out_q.video_en;
  assign seq_state = state_q;

endmodule

// File: tb/tb_hdmi_reset_seq.sv
// Self-checking bench for hdmi_reset_seq: directed latency cases plus randomized traffic.
module tb_hdmi_reset_seq;

  localparam int unsigned L       = 8;
  localparam int unsigned G       = 4;
  localparam int unsigned LW      = 2;
  localparam int          LossMax = 3;

  logic       clk_25mhz = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_restart = 1'b0;
  logic       rst_tmds, rst_px, video_en;
  logic [2:0] seq_state;
`ifdef HDMI_RESET_SEQ_LOSS_COUNT_EN
  logic [LW-1:0] loss_count;
`endif

  hdmi_reset_seq #(
    .LOCK_STABLE_CYCLES (L),
    .STAGE_GAP          (G),
    .LOSS_CNT_W         (LW)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .soft_restart (soft_restart),
    .rst_tmds     (rst_tmds),
    .rst_px       (rst_px),
    .video_en     (video_en),
`ifdef HDMI_RESET_SEQ_LOSS_COUNT_EN
    .loss_count   (loss_count),
`endif
    .seq_state    (seq_state)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: phase number, cycles spent in the phase, length of the
  // current run of consecutive synchronised lock-high samples.
  int   m_phase = 0;
  int   m_elapsed = 0;
  int   m_run = 0;
  int   m_loss = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int out_code(input int ph);
    int rt, rp, ve;
    rt = (ph == 0 || ph == 4) ? 1 : 0;
    rp = (ph == 0 || ph == 1 || ph == 4) ? 1 : 0;
    ve = (ph == 3) ? 1 : 0;
    return rt * 32 + rp * 16 + ve * 8 + ph;
  endfunction

  task automatic enter(input int ph);
    m_phase   = ph;
    m_elapsed = 0;
    m_run     = 0;
  endtask

  task automatic go_fault(input logic lk);
    if (!lk && m_loss < LossMax) m_loss++;
    enter(4);
  endtask

  task automatic model_step(input logic r, input logic p, input logic s);
    logic lk;
    if (r) begin
      enter(0);
      m_loss = 0;
      m_s1   = 1'b0;
      m_s2   = 1'b0;
      return;
    end
    lk = m_s2;
    case (m_phase)
      0: begin
        m_run = lk ? m_run + 1 : 0;
        if (m_run == L) enter(1);
      end
      1, 2: begin
        if (!lk || s) go_fault(lk);
        else begin
          m_elapsed++;
          if (m_elapsed == G) enter(m_phase + 1);
        end
      end
      3: if (!lk || s) go_fault(lk);
      default: begin
        m_elapsed++;
        if (m_elapsed == G) enter(0);
      end
    endcase
    m_s2 = m_s1;
    m_s1 = p;
  endtask

  task automatic tick(input logic r, input logic p, input logic s);
    reset        = r;
    pll_locked   = p;
    soft_restart = s;
    @(posedge clk_25mhz);
    model_step(r, p, s);
    #1;
    check_eq("outputs", 32'({rst_tmds, rst_px, video_en, seq_state}), out_code(m_phase));
`ifdef HDMI_RESET_SEQ_LOSS_COUNT_EN
    check_eq("loss_count_model", 32'(loss_count), m_loss);
`endif
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
    check_eq("reset_vals", 32'({rst_tmds, rst_px, video_en, seq_state}), 32'h30);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    for (int i = 0; i < budget && seq_state != st; i++) tick(1'b0, 1'b1, 1'b0);
    check_eq(tag, 32'(seq_state), 32'(st));
  endtask

  // Drives lock high from edge 0 and records when each output changes.
  task automatic measure(input int soft_at_a, input int soft_at_b,
                         output int t_tmds, output int t_px, output int t_ve);
    t_tmds = -1;
    t_px   = -1;
    t_ve   = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b1, (k == soft_at_a || k == soft_at_b));
      if (t_tmds < 0 && !rst_tmds) t_tmds = k;
      if (t_px < 0 && !rst_px) t_px = k;
      if (t_ve < 0 && video_en) t_ve = k;
    end
  endtask

  initial begin
    int   t_tmds, t_px, t_ve, n4, early;
    logic p;

    // Clean power-up
    do_reset(4);
    measure(-1, -1, t_tmds, t_px, t_ve);
    check_eq("lat_tmds", t_tmds, L + 1);
    check_eq("lat_px", t_px, L + 1 + G);
    check_eq("lat_video", t_ve, L + 1 + 2 * G);

    // Lock loss in RUN
    tick(1'b0, 1'b0, 1'b0);
    check_eq("loss_edge0_video", 32'(video_en), 1);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("loss_edge1_video", 32'(video_en), 1);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("loss_edge2_outs", 32'({rst_tmds, rst_px, video_en, seq_state}), 32'h34);
    n4 = 1;
    for (int i = 0; i < 20 && seq_state == 3'd4; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (seq_state == 3'd4) n4++;
    end
    check_eq("fault_len", n4, G);
    check_eq("fault_exit_state", 32'(seq_state), 0);
    wait_state(3'd3, 100, "reseq_run");

    // Unstable lock
    do_reset(2);
    early = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, (i < 5), 1'b0);
      if (!rst_tmds) early = 1;
    end
    check_eq("unstable_early", early, 0);
    measure(-1, -1, t_tmds, t_px, t_ve);
    check_eq("unstable_tmds", t_tmds, L + 1);

    // Soft restart in WAIT_LOCK is ignored
    do_reset(2);
    measure(3, 5, t_tmds, t_px, t_ve);
    check_eq("soft_wait_tmds", t_tmds, L + 1);

    // Soft restart in REL_PX
    do_reset(2);
    wait_state(3'd2, 100, "reach_relpx");
    tick(1'b0, 1'b1, 1'b1);
    check_eq("soft_relpx_fault", 32'(seq_state), 4);

    // Reset in REL_TMDS
    wait_state(3'd1, 100, "reach_reltmds");
    tick(1'b1, 1'b1, 1'b0);
    check_eq("reset_mid", 32'({rst_tmds, rst_px, video_en, seq_state}), 32'h30);

`ifdef HDMI_RESET_SEQ_LOSS_COUNT_EN
    do_reset(2);
    wait_state(3'd3, 100, "lc_run0");
    tick(1'b0, 1'b1, 1'b1);
    check_eq("lc_soft0", 32'(loss_count), 0);
    for (int n = 0; n < 5; n++) begin
      wait_state(3'd3, 100, "lc_run");
      tick(1'b0, 1'b0, 1'b0);
      wait_state(3'd4, 10, "lc_fault");
      check_eq("lc_loss", 32'(loss_count), (n + 1 > LossMax) ? LossMax : n + 1);
      if (n == 0) begin
        wait_state(3'd3, 100, "lc_run1");
        tick(1'b0, 1'b1, 1'b1);
        check_eq("lc_soft1", 32'(loss_count), 1);
      end
    end
`endif

    // Randomized traffic against the model
    do_reset(2);
    p = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (p) p = ($urandom_range(0, 149) != 0);
      else   p = ($urandom_range(0, 3) == 0);
      tick(($urandom_range(0, 599) == 0), p, ($urandom_range(0, 119) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
